// File: rtl/walk_seq_ctrl.sv
// Walking-one sequencer: drives seed, walking-one and trailing zero patterns into a
// combinational datapath and reports each result. Optional signature: WALK_SEQ_SIGNATURE_EN.
module walk_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 1,
    parameter int IDXW  = $clog2(WIDTH + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_pat_out,
    input  logic [WIDTH-1:0]  i_res_in,
    output logic              o_res_valid,
    output logic [WIDTH-1:0]  o_res_data,
    output logic [IDXW-1:0]   o_res_idx,
    output logic [WIDTH-1:0]  o_signature
);

    localparam int               HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [IDXW-1:0]  LAST_STEP = IDXW'(WIDTH + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
    localparam logic [WIDTH-1:0] ONE_HOT0  = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDXW-1:0]  r_step;
    logic [HW-1:0]    r_hold;
    logic             w_step_end;
    logic             w_capture;
    logic             w_start_ok;
    logic [WIDTH-1:0] w_pat;

    assign w_step_end = (r_state == S_RUN) && (r_hold == HOLD_LAST);
    // An abort on the sampling cycle kills the capture, so no stale pulse follows.
    assign w_capture  = w_step_end && !i_abort;
    assign w_start_ok = (r_state == S_IDLE) && i_start && !i_abort;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN: begin
                if (i_abort)
                    w_state_nxt = S_IDLE;
                else if (w_step_end && (r_step == LAST_STEP))
                    w_state_nxt = S_FIN;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pat = '0;
        if ((r_state == S_RUN) && (r_step != '0) && (r_step != LAST_STEP))
            w_pat = ONE_HOT0 << (r_step - 1'b1);
    end

    // NOTE: state and capture registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_hold      <= '0;
            o_res_valid <= 1'b0;
            o_res_data  <= '0;
            o_res_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            o_res_valid <= w_capture;
            if (w_capture) begin
                o_res_data <= i_res_in;
                o_res_idx  <= r_step;
            end
            if ((r_state == S_RUN) && !i_abort) begin
                if (w_step_end) begin
                    r_hold <= '0;
                    r_step <= r_step + 1'b1;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end else begin
                r_hold <= '0;
                r_step <= '0;
            end
        end
    end

    assign o_busy    = (r_state == S_RUN);
    assign o_done    = (r_state == S_FIN);
    assign o_pat_out = w_pat;

`ifdef WALK_SEQ_SIGNATURE_EN
    logic [WIDTH-1:0] r_sig;

    // Rotate-left-and-xor over exactly the samples reported on o_res_valid.
    always_ff @(posedge clk) begin
        if (rst)
            r_sig <= '0;
        else if (w_start_ok)
            r_sig <= '0;
        else if (w_capture)
            r_sig <= {r_sig[WIDTH-2:0], r_sig[WIDTH-1]} ^ i_res_in;
    end

    assign o_signature = r_sig;
`else
    assign o_signature = '0;
`endif

endmodule

// File: tb/tb_walk_seq_ctrl.sv
// Directed bench for walk_seq_ctrl: one HOLD=1 instance and one HOLD=3 instance, WIDTH=8.
module tb_walk_seq_ctrl;

`ifdef WALK_SEQ_SIGNATURE_EN
    localparam logic [7:0] SIG_CONST = 8'hFC;
    localparam logic [7:0] SIG_ABORT = 8'h04;
`else
    localparam logic [7:0] SIG_CONST = 8'h00;
    localparam logic [7:0] SIG_ABORT = 8'h00;
`endif

    logic       clk;
    logic       rst;
    logic       start1, abort1, const1;
    logic       start3, abort3;
    logic       busy1, done1, rv1;
    logic       busy3, done3, rv3;
    logic [7:0] pat1, res1, rdata1, sig1;
    logic [7:0] pat3, rdata3, sig3;
    logic [3:0] ridx1, ridx3;
    logic [7:0] tbl [10];
    int         checks;
    int         errors;

    assign res1 = const1 ? 8'h01 : pat1;

    walk_seq_ctrl #(.WIDTH(8), .HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_abort(abort1),
        .o_busy(busy1), .o_done(done1), .o_pat_out(pat1), .i_res_in(res1),
        .o_res_valid(rv1), .o_res_data(rdata1), .o_res_idx(ridx1), .o_signature(sig1)
    );

    walk_seq_ctrl #(.WIDTH(8), .HOLD(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_start(start3), .i_abort(abort3),
        .o_busy(busy3), .o_done(done3), .o_pat_out(pat3), .i_res_in(pat3),
        .o_res_valid(rv3), .o_res_data(rdata3), .o_res_idx(ridx3), .o_signature(sig3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
        rst = 1'b1; start1 = 1'b1; abort1 = 1'b0; const1 = 1'b0;
        start3 = 1'b1; abort3 = 1'b0;

        // Reset with start held: nothing may start.
        cyc(); cyc();
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_rv1", rv1, 0);
        check("rst_pat1", pat1, 8'h00);
        check("rst_rdata1", rdata1, 0);
        check("rst_ridx1", ridx1, 0);
        check("rst_sig1", sig1, 0);
        check("rst_busy3", busy3, 0);
        rst = 1'b0; start1 = 1'b0; start3 = 1'b0;
        cyc();
        check("post_rst_busy1", busy1, 0);
        check("post_rst_pat1", pat1, 8'h00);

        // Identity datapath, HOLD=1: patterns at t+1..t+10, results at t+2..t+11.
        start1 = 1'b1; cyc(); start1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("id_pat", pat1, tbl[k]);
            check("id_busy", busy1, 1);
            check("id_done", done1, 0);
            if (k == 0) begin
                check("id_rv0", rv1, 0);
            end else begin
                check("id_rv", rv1, 1);
                check("id_ridx", ridx1, k - 1);
                check("id_rdata", rdata1, tbl[k-1]);
            end
            cyc();
        end
        check("id_done_t11", done1, 1);
        check("id_busy_t11", busy1, 0);
        check("id_pat_t11", pat1, 8'h00);
        check("id_rv_t11", rv1, 1);
        check("id_ridx_t11", ridx1, 9);
        check("id_rdata_t11", rdata1, 8'h00);
        check("id_sig", sig1, 8'h00);
        cyc();
        check("id_done_t12", done1, 0);
        check("id_rv_t12", rv1, 0);
        check("id_ridx_hold", ridx1, 9);

        // HOLD=3 with a stray start pulse mid-sequence.
        start3 = 1'b1; cyc(); start3 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            check("h3_pat", pat3, tbl[(c-1)/3]);
            check("h3_busy", busy3, 1);
            check("h3_done", done3, 0);
            if (c >= 4 && ((c - 1) % 3) == 0) begin
                check("h3_rv", rv3, 1);
                check("h3_ridx", ridx3, (c - 1) / 3 - 1);
                check("h3_rdata", rdata3, tbl[(c-1)/3 - 1]);
            end else begin
                check("h3_rv_off", rv3, 0);
            end
            start3 = (c == 5);
            cyc();
        end
        start3 = 1'b0;
        check("h3_done_t31", done3, 1);
        check("h3_rv_t31", rv3, 1);
        check("h3_ridx_t31", ridx3, 9);
        check("h3_busy_t31", busy3, 0);
        cyc();
        check("h3_idle_busy", busy3, 0);
        check("h3_idle_done", done3, 0);
        check("h3_idle_pat", pat3, 8'h00);

        // Constant 0x01 datapath: ten captures, signature 0xFC when enabled.
        const1 = 1'b1;
        start1 = 1'b1; cyc(); start1 = 1'b0;
        check("c1_rv_t1", rv1, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            check("c1_rv", rv1, 1);
            check("c1_rdata", rdata1, 8'h01);
            check("c1_ridx", ridx1, i - 1);
        end
        check("c1_done", done1, 1);
        check("c1_sig", sig1, SIG_CONST);
        cyc();
        check("c1_sig_hold", sig1, SIG_CONST);
        const1 = 1'b0;

        // Abort during step 4.
        start1 = 1'b1; cyc(); start1 = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        check("ab_pat_step4", pat1, 8'h08);
        abort1 = 1'b1; cyc(); abort1 = 1'b0;
        check("ab_busy", busy1, 0);
        check("ab_pat", pat1, 8'h00);
        check("ab_rv", rv1, 0);
        check("ab_ridx", ridx1, 3);
        check("ab_sig", sig1, SIG_ABORT);
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("ab_quiet", {done1, rv1, busy1}, 0);
        end
        check("ab_sig_hold", sig1, SIG_ABORT);
        start1 = 1'b1; cyc(); start1 = 1'b0;
        check("ab_restart_busy", busy1, 1);
        cyc();
        check("ab_restart_rv", rv1, 1);
        check("ab_restart_ridx", ridx1, 0);
        for (int i = 0; i < 9; i++) cyc();
        check("ab_restart_done", done1, 1);
        cyc();

        // Start held high: the next sequence is accepted in the IDLE cycle after done.
        start1 = 1'b1; cyc();
        for (int i = 0; i < 10; i++) cyc();
        check("b2b_done1", done1, 1);
        check("b2b_ridx9", ridx1, 9);
        cyc();
        check("b2b_idle_busy", busy1, 0);
        check("b2b_idle_rv", rv1, 0);
        check("b2b_idle_done", done1, 0);
        cyc();
        check("b2b_run_busy", busy1, 1);
        check("b2b_run_rv", rv1, 0);
        cyc();
        check("b2b_rv0", rv1, 1);
        check("b2b_ridx0", ridx1, 0);
        start1 = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        check("b2b_done2", done1, 1);
        cyc();
        check("b2b_end_busy", busy1, 0);

        // Abort and start together in IDLE: abort wins.
        start1 = 1'b1; abort1 = 1'b1; cyc();
        check("abst_busy", busy1, 0);
        start1 = 1'b0; abort1 = 1'b0; cyc();
        check("abst_busy_after", busy1, 0);

        // Reset in the middle of a HOLD=3 sequence.
        start3 = 1'b1; cyc(); start3 = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("mr_pre_pat", pat3, 8'h01);
        rst = 1'b1; cyc();
        check("mr_busy", busy3, 0);
        check("mr_pat", pat3, 8'h00);
        check("mr_rv", rv3, 0);
        check("mr_rdata", rdata3, 0);
        check("mr_ridx", ridx3, 0);
        check("mr_sig", sig3, 0);
        rst = 1'b0; cyc();
        check("mr_idle", busy3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
